// File: rtl/apb3_timer_irq.sv
// apb3_timer_irq
// APB3 slave with a 32-bit down-counting timer and a level interrupt.
// Every access gets exactly one wait state.
//
// Register map (PADDR[4:2] selects the word, PADDR[1:0] is ignored):
//   0x00 CTRL   RW  {IE, AUTO, EN}
//   0x04 LOAD   RW  reload value; a write also loads COUNT
//   0x08 COUNT  RO  current count
//   0x0C STATUS W1C bit0 PEND
//   0x10 EXPCNT RO  saturating expiry counter; any write clears it
//
// Ports:
//   io_systemClk    sole clock, rising edge
//   io_systemReset  synchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA  APB3 request
//   PRDATA/PREADY/PSLVERROR           APB3 response
//   userInterrupt   PEND & IE, driven from registers only
module apb3_timer_irq #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] RESET_LOAD = 32'd999_999_999
) (
  input  logic                  io_systemClk,
  input  logic                  io_systemReset,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERROR,
  output logic                  userInterrupt
);

  typedef enum logic {ST_WAIT, ST_DONE} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_en;
  logic        r_auto;
  logic        r_ie;
  logic        r_pend;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic [15:0] r_expCnt;
  logic [31:0] r_prdata;
  logic        r_slvErr;

  logic        w_access;
  logic        w_pready;
  logic        w_mapped;
  logic [2:0]  w_regSel;
  logic        w_commitWr;
  logic        w_wrCtrl;
  logic        w_wrLoad;
  logic        w_wrStatus;
  logic        w_wrExpCnt;
  logic        w_expire;
  logic [31:0] w_readData;
  logic [1:0]  w_unusedAddrBits;

  assign w_unusedAddrBits = PADDR[1:0];
  assign w_regSel   = PADDR[4:2];
  assign w_mapped   = (PADDR[ADDR_WIDTH-1:5] == '0) && (w_regSel <= 3'd4);
  assign w_access   = PSEL & PENABLE;
  assign w_pready   = (r_state == ST_DONE);

  // A write takes effect only in the completing ACCESS cycle.
  assign w_commitWr = w_access & w_pready & PWRITE & w_mapped;
  assign w_wrCtrl   = w_commitWr & (w_regSel == 3'd0);
  assign w_wrLoad   = w_commitWr & (w_regSel == 3'd1);
  assign w_wrStatus = w_commitWr & (w_regSel == 3'd3);
  assign w_wrExpCnt = w_commitWr & (w_regSel == 3'd4);

  // A running timer that has reached zero expires on this edge.
  assign w_expire   = r_en & (r_count == 32'd0);

  assign PREADY        = w_pready;
  assign PRDATA        = r_prdata;
  assign PSLVERROR     = r_slvErr;
  assign userInterrupt = r_pend & r_ie;

  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // WAIT covers the first ACCESS cycle; DONE is the completing cycle and
  // always falls back to WAIT so back-to-back transfers each get a wait state.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_WAIT: if (w_access) w_stateNext = ST_DONE;
      ST_DONE: w_stateNext = ST_WAIT;
    endcase
  end

  always_comb begin
    w_readData = 32'd0;
    case (w_regSel)
      3'd0:    w_readData = {29'd0, r_ie, r_auto, r_en};
      3'd1:    w_readData = r_load;
      3'd2:    w_readData = r_count;
      3'd3:    w_readData = {31'd0, r_pend};
      3'd4:    w_readData = {16'd0, r_expCnt};
      default: w_readData = 32'd0;
    endcase
  end

  // Response is captured at the end of the wait cycle, so it is present
  // exactly while PREADY is high and cleared again afterwards.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      r_prdata <= 32'd0;
      r_slvErr <= 1'b0;
    end else if ((r_state == ST_WAIT) && w_access) begin
      r_prdata <= (!PWRITE && w_mapped) ? w_readData : 32'd0;
      r_slvErr <= ~w_mapped;
    end else begin
      r_prdata <= 32'd0;
      r_slvErr <= 1'b0;
    end
  end

  // Timer state. Register writes override the natural expiry/decrement for
  // the fields they touch, but an expiry in the same cycle still sets PEND.
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_ie     <= 1'b0;
      r_load   <= RESET_LOAD;
      r_count  <= 32'd0;
      r_pend   <= 1'b0;
      r_expCnt <= 16'd0;
    end else begin
      if (w_wrCtrl) begin
        r_en   <= PWDATA[0];
        r_auto <= PWDATA[1];
        r_ie   <= PWDATA[2];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end

      if (w_wrLoad) begin
        r_load <= PWDATA;
      end

      if (w_wrLoad) begin
        r_count <= PWDATA;
      end else if (w_wrCtrl && PWDATA[0] && !r_en) begin
        r_count <= r_load;
      end else if (w_expire) begin
        r_count <= r_auto ? r_load : 32'd0;
      end else if (r_en) begin
        r_count <= r_count - 32'd1;
      end

      if (w_expire) begin
        r_pend <= 1'b1;
      end else if (w_wrStatus && PWDATA[0]) begin
        r_pend <= 1'b0;
      end

      // A clear that coincides with an expiry keeps that expiry counted.
      if (w_wrExpCnt) begin
        r_expCnt <= {15'd0, w_expire};
      end else if (w_expire && (r_expCnt != 16'hFFFF)) begin
        r_expCnt <= r_expCnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb3_timer_irq.sv
// tb_apb3_timer_irq
// Drives APB3 transfers into apb3_timer_irq. Expected responses are pushed
// into a scoreboard queue when a transfer is issued; a monitor pops them when
// PREADY rises. The reference model describes the timer analytically: from
// an anchor (cycle, count) it computes count, EN and the number of expiries
// at any later cycle with plain arithmetic, re-anchoring at each write.
module tb_apb3_timer_irq;

  localparam int          AW       = 16;
  localparam logic [31:0] RST_LOAD = 32'd999_999_999;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERROR;
  logic          userInterrupt;

  apb3_timer_irq #(.ADDR_WIDTH(AW), .RESET_LOAD(RST_LOAD)) dut (
    .io_systemClk   (clk),
    .io_systemReset (rst),
    .PADDR          (PADDR),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .PWDATA         (PWDATA),
    .PRDATA         (PRDATA),
    .PREADY         (PREADY),
    .PSLVERROR      (PSLVERROR),
    .userInterrupt  (userInterrupt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  resp_t  expQ[$];
  bit     modelOn = 1'b0;
  int     accessCycles = 0;
  resp_t  monR;

  // Reference model state, valid from anchor cycle tA onwards.
  bit     mEn, mAuto, mIe, mPend;
  longint mLoad, mExp, tA, cA;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit isMapped(input logic [AW-1:0] addr);
    return (addr[AW-1:5] == '0) && (addr[4:2] <= 3'd4);
  endfunction

  function automatic longint sat(input longint x);
    return (x > 65535) ? 65535 : x;
  endfunction

  // Timer as seen in cycle t: count, EN and expiries since the anchor.
  // First expiry falls cA+1 cycles after the anchor, then every LOAD+1.
  function automatic void evalAt(input longint t, output longint cnt, output bit en, output longint nexp);
    longint e, k;
    cnt  = cA;
    en   = mEn;
    nexp = 0;
    if (mEn && (t > tA)) begin
      e = t - tA;
      if (e <= cA) begin
        cnt = cA - e;
      end else begin
        k = e - cA - 1;
        if (mAuto) begin
          cnt  = mLoad - (k % (mLoad + 1));
          nexp = 1 + k / (mLoad + 1);
        end else begin
          cnt  = 0;
          en   = 1'b0;
          nexp = 1;
        end
      end
    end
  endfunction

  function automatic void modelReset();
    mEn = 0; mAuto = 0; mIe = 0; mPend = 0;
    mLoad = longint'(RST_LOAD); mExp = 0; tA = cyc; cA = 0;
  endfunction

  function automatic resp_t modelRead(input logic [AW-1:0] addr, input longint t);
    resp_t  r;
    longint c, n;
    bit     en;
    evalAt(t, c, en, n);
    r.err  = 1'b0;
    r.data = 32'd0;
    case (addr[4:2])
      3'd0:    r.data = {29'd0, mIe, mAuto, en};
      3'd1:    r.data = 32'(mLoad);
      3'd2:    r.data = 32'(c);
      3'd3:    r.data = {31'd0, (mPend || (n > 0))};
      3'd4:    r.data = 32'(sat(mExp + n));
      default: r.data = 32'd0;
    endcase
    return r;
  endfunction

  // A write committed on the edge into cycle tw. Writes win over the natural
  // evolution for the fields they touch; an expiry on that edge still sets PEND.
  function automatic void applyWrite(input logic [AW-1:0] addr, input logic [31:0] d, input longint tw);
    longint c0, n0, c1, n1, ex;
    bit     en0, en1, pend, expNow;
    evalAt(tw - 1, c0, en0, n0);
    evalAt(tw, c1, en1, n1);
    expNow = (n1 > n0);
    pend   = mPend || (n1 > 0);
    ex     = sat(mExp + n1);
    if (isMapped(addr)) begin
      case (addr[4:2])
        3'd0: begin
          if (!en0 && d[0]) c1 = mLoad;
          en1 = d[0]; mAuto = d[1]; mIe = d[2];
        end
        3'd1: begin mLoad = longint'(d); c1 = longint'(d); end
        3'd3: if (d[0] && !expNow) pend = 1'b0;
        3'd4: ex = expNow ? 1 : 0;
        default: ;
      endcase
    end
    mEn = en1; cA = c1; tA = tw; mPend = pend; mExp = ex;
  endfunction

  function automatic logic expIrq(input longint t);
    longint c, n;
    bit     en;
    evalAt(t, c, en, n);
    return mIe && (mPend || (n > 0));
  endfunction

  function automatic longint countAt(input longint t);
    longint c, n;
    bit     en;
    evalAt(t, c, en, n);
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One APB transfer, started at posedge+1; returns at posedge+1 after commit.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data);
    resp_t  r;
    longint setupCyc;
    bit     done;
    done     = 1'b0;
    setupCyc = cyc;
    if (!isMapped(addr)) begin
      r.data = 32'd0; r.err = 1'b1;
    end else if (wr) begin
      r.data = 32'd0; r.err = 1'b0;
    end else begin
      r = modelRead(addr, setupCyc + 1);
    end
    expQ.push_back(r);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge clk);
    #1;
    PENABLE = 1'b1;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      done = PREADY;
      @(posedge clk);
      #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    checkOutput("pready_within_bound", {31'd0, done}, 32'd1);
    if (done && wr) applyWrite(addr, data, cyc);
  endtask

  always @(negedge clk) begin
    if (modelOn && !rst) begin
      if (!PREADY) begin
        checkOutput("prdata_zero_when_not_ready", PRDATA, 32'd0);
        checkOutput("pslverror_zero_when_not_ready", {31'd0, PSLVERROR}, 32'd0);
      end
      if (PSEL && PENABLE) begin
        if (PREADY) begin
          checkOutput("wait_states", accessCycles, 32'd1);
          checkOutput("scoreboard_has_entry", {31'd0, (expQ.size() > 0)}, 32'd1);
          if (expQ.size() > 0) begin
            monR = expQ.pop_front();
            checkOutput("prdata", PRDATA, monR.data);
            checkOutput("pslverror", {31'd0, PSLVERROR}, {31'd0, monR.err});
          end
          accessCycles = 0;
        end else begin
          accessCycles++;
        end
      end else begin
        accessCycles = 0;
      end
      checkOutput("user_interrupt", {31'd0, userInterrupt}, {31'd0, expIrq(cyc)});
    end else begin
      accessCycles = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            sel;
    bit            wr;

    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    idle(3);
    rst = 1'b0;
    modelReset();
    modelOn = 1'b1;

    $display("[TB] reset values");
    checkOutput("reset_pready", {31'd0, PREADY}, 32'd0);
    checkOutput("reset_irq", {31'd0, userInterrupt}, 32'd0);
    for (int a = 0; a < 5; a++) applyStimulus(1'b0, 16'(a * 4), 32'd0);

    $display("[TB] one-shot LOAD=4 CTRL=0x5");
    applyStimulus(1'b1, 16'h04, 32'd4);
    applyStimulus(1'b1, 16'h00, 32'h5);
    idle(4);
    checkOutput("oneshot_irq_cycle4", {31'd0, userInterrupt}, 32'd0);
    idle(1);
    checkOutput("oneshot_irq_cycle5", {31'd0, userInterrupt}, 32'd1);
    applyStimulus(1'b0, 16'h00, 32'd0);
    applyStimulus(1'b0, 16'h10, 32'd0);
    applyStimulus(1'b0, 16'h08, 32'd0);
    applyStimulus(1'b1, 16'h0C, 32'h1);
    checkOutput("oneshot_w1c_irq", {31'd0, userInterrupt}, 32'd0);
    applyStimulus(1'b1, 16'h10, 32'd0);

    $display("[TB] auto-reload LOAD=2 CTRL=0x7");
    applyStimulus(1'b1, 16'h04, 32'd2);
    applyStimulus(1'b1, 16'h00, 32'h7);
    idle(12);
    applyStimulus(1'b0, 16'h10, 32'd0);
    for (int i = 0; i < 6 && countAt(cyc + 2) != 2; i++) idle(1);
    applyStimulus(1'b1, 16'h0C, 32'h1);
    checkOutput("auto_w1c_drops_irq", {31'd0, userInterrupt}, 32'd0);

    $display("[TB] W1C colliding with expiry");
    for (int i = 0; i < 6 && countAt(cyc + 2) != 0; i++) idle(1);
    applyStimulus(1'b1, 16'h0C, 32'h1);
    checkOutput("collide_irq_held", {31'd0, userInterrupt}, 32'd1);
    applyStimulus(1'b0, 16'h0C, 32'd0);
    applyStimulus(1'b1, 16'h00, 32'h4);

    $display("[TB] unmapped read 0x18");
    applyStimulus(1'b0, 16'h18, 32'd0);
    applyStimulus(1'b0, 16'h00, 32'd0);

    $display("[TB] reset mid-count");
    applyStimulus(1'b1, 16'h04, 32'd100);
    applyStimulus(1'b1, 16'h00, 32'h5);
    idle(5);
    checkOutput("pre_reset_irq", {31'd0, userInterrupt}, 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    modelReset();
    checkOutput("post_reset_irq", {31'd0, userInterrupt}, 32'd0);
    applyStimulus(1'b0, 16'h00, 32'd0);
    applyStimulus(1'b0, 16'h04, 32'd0);
    applyStimulus(1'b0, 16'h08, 32'd0);

    $display("[TB] reset aborts in-flight write");
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 16'h04; PWDATA = 32'd123; PENABLE = 1'b0;
    idle(1);
    PENABLE = 1'b1; rst = 1'b1;
    idle(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rst = 1'b0;
    modelReset();
    applyStimulus(1'b0, 16'h04, 32'd0);

    $display("[TB] LOAD write during run");
    applyStimulus(1'b1, 16'h04, 32'd50);
    applyStimulus(1'b1, 16'h00, 32'h5);
    idle(10);
    applyStimulus(1'b1, 16'h04, 32'd10);
    applyStimulus(1'b0, 16'h08, 32'd0);
    idle(7);
    checkOutput("reload_irq_cycle10", {31'd0, userInterrupt}, 32'd0);
    idle(1);
    checkOutput("reload_irq_cycle11", {31'd0, userInterrupt}, 32'd1);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8) addr = 16'(sel * 4 + int'($urandom_range(0, 3)));
      else         addr = 16'(($urandom_range(1, 2047) << 5) | $urandom_range(0, 31));
      wr   = 1'($urandom_range(0, 1));
      data = (sel == 1) ? $urandom_range(0, 12) : $urandom;
      applyStimulus(wr, addr, data);
      idle(int'($urandom_range(0, 3)));
    end

    idle(4);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb3_timer_irq.md
APB3_TIMER_IRQ -- requirements
Module: apb3_timer_irq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, APB address width.
REQ-002 SHALL have parameter RESET_LOAD, default 32'd999_999_999, reset value of LOAD (10 s at 100 MHz).
REQ-003 SHALL have port io_systemClk  input  1  sole clock; all state rising-edge.
REQ-004 SHALL have port io_systemReset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port PADDR  input  ADDR_WIDTH  APB3 address; bits [4:2] decoded, [1:0] ignored.
REQ-006 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB3 controls.
REQ-007 SHALL have port PWDATA  input  32  write data.
REQ-008 SHALL have port PRDATA  output  32  read data.
REQ-009 SHALL have port PREADY  output  1  transfer complete.
REQ-010 SHALL have port PSLVERROR  output  1  decode error.
REQ-011 SHALL have port userInterrupt  output  1  level interrupt to SoC userInterruptA.

Function
REQ-012 SHALL implement this register map: 0x00 CTRL RW {bit0 EN, bit1 AUTO, bit2 IE}; 0x04 LOAD RW 32; 0x08 COUNT RO 32; 0x0C STATUS bit0 PEND, W1C; 0x10 EXPCNT RO 16 (expiry count, saturates at 0xFFFF; any write clears it).
REQ-013 SHALL read unused bits as 0.
REQ-014 SHALL use 0x14 to 0x1C and any address with PADDR[ADDR_WIDTH-1:5] != 0 as unmapped.
REQ-015 SHALL use APB states IDLE (PSEL=0), SETUP (PSEL=1, PENABLE=0) and ACCESS (PSEL=1, PENABLE=1).
REQ-016 SHALL use a 2-state FSM, WAIT and DONE: PREADY=0 in the first ACCESS cycle and PREADY=1 in the second, giving exactly one wait state.
REQ-017 SHALL return the FSM to WAIT one cycle after DONE.
REQ-018 SHALL commit writes only in the cycle where PSEL & PENABLE & PREADY.
REQ-019 SHALL register PRDATA; it SHALL be valid while PREADY=1 and 0 otherwise.
REQ-020 SHALL assert PSLVERROR only with PREADY=1 for an unmapped address.
REQ-021 SHALL ignore writes to unmapped addresses and to COUNT.
REQ-022 SHALL load COUNT from LOAD when EN goes 0->1 by a write.
REQ-023 SHALL load COUNT from PWDATA on any LOAD write, whether or not EN=1.
REQ-024 SHALL decrement COUNT by 1 per cycle while EN=1 and COUNT != 0.
REQ-025 SHALL treat COUNT==0 with EN=1 as an expiry cycle: PEND<=1; EXPCNT<=EXPCNT+1 (saturating); if AUTO=1 then COUNT<=LOAD, else EN<=0 and COUNT holds 0.
REQ-026 SHALL give a period of LOAD+1 cycles; LOAD=0 with AUTO=1 SHALL expire every cycle.
REQ-027 SHALL give priority when an expiry and a STATUS W1C of PEND fall in the same cycle: set wins, PEND=1.
REQ-028 SHALL give priority when an expiry and a LOAD write fall in the same cycle: the write wins for COUNT; PEND is still set.
REQ-029 SHALL give priority when an expiry and a CTRL write of EN=0 fall in the same cycle: EN=0, PEND is still set.
REQ-030 SHALL hold COUNT when EN=0, and SHALL keep EN and COUNT unchanged by an EN 1->1 write.
REQ-031 SHALL drive userInterrupt = PEND & IE, combinationally from registers, with no glitch path from APB inputs.

Reset
REQ-032 SHALL, on io_systemReset=1 at a clock edge, set CTRL=0, LOAD=RESET_LOAD, COUNT=0, PEND=0, EXPCNT=0, FSM=WAIT, PRDATA=0, PREADY=0, PSLVERROR=0 and userInterrupt=0.
REQ-033 SHALL let reset abort an in-flight APB transfer with no register update.
REQ-034 SHALL give reset priority over all other events.

Verification
REQ-035 SHALL be verified for one-shot: LOAD=4, CTRL=0x5 -> COUNT reads 4,3,..,0; PEND=1 and userInterrupt=1 exactly 5 cycles after the enable commit; EN reads 0; EXPCNT=1.
REQ-036 SHALL be verified for auto-reload: LOAD=2, CTRL=0x7, run 12 cycles -> 4 expiries; EXPCNT=4; STATUS W1C 0x1 drops userInterrupt the cycle after commit.
REQ-037 SHALL be verified for a W1C colliding with an expiry: PEND stays 1 and userInterrupt stays 1.
REQ-038 SHALL be verified for an unmapped read of 0x18 -> PREADY=1 after one wait state, PSLVERROR=1, PRDATA=0; no state change.
REQ-039 SHALL be verified for reset mid-count: COUNT=100, EN=1, io_systemReset for 1 cycle -> CTRL=0, LOAD reads RESET_LOAD, userInterrupt=0, COUNT=0.
REQ-040 SHALL be verified for a LOAD write during a run (COUNT=50, write LOAD=10) -> COUNT reads 10 then decrements, and expiry occurs 11 cycles after the write.
